// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
// The FSM state encoding lives here so the bench and sub-blocks agree on it.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitDone,
    StGap
  } state_e;

  localparam int unsigned CLKS_PER_BIT         = 217;
  localparam int unsigned GAP_CLKS_DEFAULT     = 0;
  localparam int unsigned TIMEOUT_CLKS_DEFAULT = 4096;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request after index
// 'last', wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last,
  output logic               found,
  output logic [2:0]         next_idx
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  always_comb begin
    int unsigned idx;
    idx      = 0;
    found    = 1'b0;
    next_idx = last;
    // k = NUM_REQ lands back on 'last', so a lone requester can win again.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last) + k) % NUM_REQ;
      if (!found && req[idx[IdxW-1:0]]) begin
        found    = 1'b1;
        next_idx = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from several requesters into one UART_TX,
// with an optional inter-frame gap and a watchdog on missing tx_done.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned GAP_CLKS     = GAP_CLKS_DEFAULT,
  parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_byte,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_dv,
  output logic [7:0]           tx_byte,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [2:0]           owner,
  output logic                 timeout_err
);

  localparam int unsigned GapW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT_CLKS);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  // Expire on the clock where the count would reach TIMEOUT_CLKS-1.
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CLKS - 2);

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               tx_dv_q;
  logic [7:0]         tx_byte_q;
  logic [2:0]         owner_q;
  logic               timeout_q;
  logic [GapW-1:0]    gap_q;
  logic [WdW-1:0]     wd_q;

  logic               pick_found;
  logic [2:0]         pick_idx;
  logic [7:0]         pick_byte;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req     (req),
    .last    (owner_q),
    .found   (pick_found),
    .next_idx(pick_idx)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == 3'(i)) pick_byte = req_byte[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      owner_q   <= 3'(NUM_REQ - 1);
      timeout_q <= 1'b0;
      gap_q     <= '0;
      wd_q      <= '0;
    end else begin
      grant_q   <= '0;
      tx_dv_q   <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Holding off while tx_active keeps a post-reset issue from
          // colliding with a frame UART_TX is still shifting out.
          if (pick_found && !tx_active) begin
            state_q   <= StSend;
            grant_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            tx_dv_q   <= 1'b1;
            tx_byte_q <= pick_byte;
            owner_q   <= pick_idx;
          end
        end
        StSend: begin
          wd_q    <= '0;
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (tx_done) begin
            gap_q   <= '0;
            state_q <= (GAP_CLKS > 0) ? StGap : StIdle;
          end else if (wd_q == WdLast) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StGap: begin
          if (gap_q == GapLast) state_q <= StIdle;
          else                  gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant       = grant_q;
  assign tx_dv       = tx_dv_q;
  assign tx_byte     = tx_byte_q;
  assign owner       = owner_q;
  assign timeout_err = timeout_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one default instance and one with a
// 50-clock inter-frame gap; inputs change and outputs are sampled on negedge.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned TO    = 4096;
  localparam int unsigned FRAME = 10 * CLKS_PER_BIT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_byte = '0;
  logic [3:0]  grant;
  logic        tx_dv, busy, timeout_err;
  logic [7:0]  tx_byte;
  logic [2:0]  owner;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;

  logic [3:0]  g_req = '0;
  logic [31:0] g_req_byte = '0;
  logic [3:0]  g_grant;
  logic        g_tx_dv, g_busy, g_timeout_err;
  logic [7:0]  g_tx_byte;
  logic [2:0]  g_owner;
  logic        g_tx_active = 1'b0;
  logic        g_tx_done = 1'b0;

  int checks = 0;
  int errors = 0;
  int seen;
  int n;
  int exp_idx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(0), .TIMEOUT_CLKS(TO)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_byte(req_byte), .grant(grant),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(50), .TIMEOUT_CLKS(TO)) u_gap (
    .clk(clk), .rst(rst), .req(g_req), .req_byte(g_req_byte), .grant(g_grant),
    .tx_dv(g_tx_dv), .tx_byte(g_tx_byte), .tx_active(g_tx_active),
    .tx_done(g_tx_done), .busy(g_busy), .owner(g_owner),
    .timeout_err(g_timeout_err)
  );

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Finish a frame from WAIT_DONE: tx_done pulse, then back to IDLE.
  task automatic finish_frame();
    tx_active = 1'b1;
    step(2);
    tx_done = 1'b1;
    step(1);
    tx_done   = 1'b0;
    tx_active = 1'b0;
  endtask

  initial begin
    // Reset values
    step(2);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_tx_dv", 32'(tx_dv), 0);
    chk("rst_tx_byte", 32'(tx_byte), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 3);
    chk("rst_timeout", 32'(timeout_err), 0);

    // Single request, full-length frame
    req_byte = 32'h443322A5;
    req      = 4'b0001;
    rst      = 1'b0;
    step(1);
    chk("single_tx_dv", 32'(tx_dv), 1);
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_tx_byte", 32'(tx_byte), 32'hA5);
    chk("single_owner", 32'(owner), 0);
    chk("single_busy_send", 32'(busy), 1);
    req       = 4'b0000;
    tx_active = 1'b1;
    step(1);
    chk("single_tx_dv_1cyc", 32'(tx_dv), 0);
    chk("single_grant_1cyc", 32'(grant), 0);
    step(FRAME - 2);
    chk("single_busy_frame", 32'(busy), 1);
    tx_done = 1'b1;
    step(1);
    tx_done   = 1'b0;
    tx_active = 1'b0;
    chk("single_idle_after_done", 32'(busy), 0);
    chk("single_no_timeout", 32'(timeout_err), 0);
    chk("single_byte_held", 32'(tx_byte), 32'hA5);
    // tx_done while IDLE must be ignored
    tx_done = 1'b1;
    step(1);
    tx_done = 1'b0;
    chk("stray_done_busy", 32'(busy), 0);
    chk("stray_done_tx_dv", 32'(tx_dv), 0);

    // Round-robin with all four requesters held
    rst = 1'b1;
    step(1);
    rst      = 1'b0;
    req      = 4'b1111;
    req_byte = 32'hD3C2B1A0;
    for (int f = 0; f < 5; f++) begin
      exp_idx = f % 4;
      step(1);
      chk("rr_tx_dv", 32'(tx_dv), 1);
      chk("rr_grant", 32'(grant), 32'h1 << exp_idx);
      chk("rr_owner", 32'(owner), 32'(exp_idx));
      chk("rr_tx_byte", 32'(tx_byte), 32'hA0 + 32'h11 * 32'(exp_idx));
      tx_active = 1'b1;
      step(9);
      tx_done = 1'b1;
      step(1);
      tx_done   = 1'b0;
      tx_active = 1'b0;
    end
    req = 4'b0000;

    // Watchdog: tx_done never arrives
    req = 4'b0100;
    step(1);
    chk("wd_tx_dv", 32'(tx_dv), 1);
    chk("wd_grant", 32'(grant), 32'h4);
    req       = 4'b0000;
    tx_active = 1'b1;
    step(TO - 1);
    chk("wd_no_early_pulse", 32'(timeout_err), 0);
    chk("wd_busy_before", 32'(busy), 1);
    step(1);
    chk("wd_pulse", 32'(timeout_err), 1);
    chk("wd_idle", 32'(busy), 0);
    step(1);
    chk("wd_pulse_1cyc", 32'(timeout_err), 0);
    tx_active = 1'b0;
    req       = 4'b1000;
    step(1);
    chk("wd_next_grant", 32'(grant), 32'h8);
    chk("wd_next_tx_dv", 32'(tx_dv), 1);
    req = 4'b0000;
    finish_frame();
    chk("wd_next_done", 32'(busy), 0);

    // tx_done coincident with watchdog expiry counts as normal completion
    req = 4'b0001;
    step(1);
    chk("coinc_tx_dv", 32'(tx_dv), 1);
    req       = 4'b0000;
    tx_active = 1'b1;
    step(TO - 1);
    tx_done = 1'b1;
    step(1);
    tx_done   = 1'b0;
    tx_active = 1'b0;
    chk("coinc_no_timeout", 32'(timeout_err), 0);
    chk("coinc_idle", 32'(busy), 0);
    step(1);
    chk("coinc_no_late_timeout", 32'(timeout_err), 0);

    // Reset mid-frame while UART_TX is still active
    req = 4'b0010;
    step(1);
    chk("rmf_first_grant", 32'(grant), 32'h2);
    tx_active = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rmf_busy", 32'(busy), 0);
    chk("rmf_owner", 32'(owner), 3);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      seen += int'(tx_dv);
    end
    chk("rmf_no_issue_active", 32'(seen), 0);
    tx_active = 1'b0;
    step(1);
    chk("rmf_grant", 32'(grant), 32'h2);
    chk("rmf_owner_after", 32'(owner), 1);
    req = 4'b0000;
    finish_frame();

    // Withdrawal: req[2] pulsed only while WAIT_DONE
    req = 4'b0001;
    step(1);
    chk("wdr_grant0", 32'(grant), 32'h1);
    req       = 4'b0000;
    tx_active = 1'b1;
    step(2);
    req = 4'b0100;
    step(1);
    req  = 4'b0000;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      seen += int'(grant[2] | tx_dv);
    end
    tx_done = 1'b1;
    step(1);
    tx_done   = 1'b0;
    tx_active = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen += int'(grant[2] | tx_dv);
    end
    chk("wdr_no_grant2", 32'(seen), 0);

    // Gap instance: two back-to-back frames from requester 0
    g_req_byte = 32'h0000005A;
    g_req      = 4'b0001;
    step(1);
    chk("gap_tx_dv1", 32'(g_tx_dv), 1);
    chk("gap_tx_byte", 32'(g_tx_byte), 32'h5A);
    g_tx_active = 1'b1;
    step(3);
    g_tx_done = 1'b1;
    step(1);
    g_tx_done   = 1'b0;
    g_tx_active = 1'b0;
    n = 0;
    while (g_busy && n < 200) begin
      n++;
      step(1);
    end
    chk("gap_cycles", 32'(n), 50);
    step(1);
    chk("gap_tx_dv2", 32'(g_tx_dv), 1);
    chk("gap_grant2", 32'(g_grant), 32'h1);
    g_req = 4'b0000;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
